// File: rtl/softmax_addr_fifo.sv
// Trace-entry buffer feeding the softmax classifier FIFO port.
// Issues one-cycle valid pulses, paced by the classifier's ready flag and a minimum idle gap.
module softmax_addr_fifo #(
    parameter int DATA_W = 13,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iPush_valid,
    input  logic [DATA_W-1:0] iPush_data,
    output logic              oPush_ready,
    input  logic              iSm_ready,
    input  logic              iFlush,
    input  logic              iClr_ovf,
    output logic              oFIFO_valid,
    output logic [DATA_W-1:0] oFIFO_data,
    output logic [ADDR_W:0]   oCount,
    output logic              oOverflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // The IDLE cycle that samples iSm_ready is the final idle cycle of the gap,
    // so the GAP state itself only needs to cover GAP-1 cycles (counter loads GAP-2).
    localparam int                CNT_W    = (GAP > 2) ? $clog2(GAP - 1) : 1;
    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'((GAP > 1) ? GAP - 2 : 0);
    localparam logic [CNT_W-1:0]  GAP_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    state_t            state_q;
    logic [CNT_W-1:0]  gap_cnt_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              ovf_q;
    logic              push_ready_q;

    logic full;
    logic push_acc;
    logic pop;

    // Full is judged on the registered count: a same-cycle pop never frees room.
    assign full     = (count_q == FULL_CNT);
    assign push_acc = iPush_valid && !full && !iFlush;
    assign pop      = (state_q == S_IDLE) && (count_q != '0) && iSm_ready && !iFlush;

    always_comb begin
        count_d = count_q;
        case ({push_acc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            mem[wr_ptr_q] <= iPush_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            gap_cnt_q    <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            ovf_q        <= 1'b0;
            push_ready_q <= 1'b1;
        end else begin
            if (iPush_valid && full) begin
                ovf_q <= 1'b1;
            end else if (iClr_ovf) begin
                ovf_q <= 1'b0;
            end

            if (iFlush) begin
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                count_q      <= '0;
                state_q      <= S_IDLE;
                gap_cnt_q    <= '0;
                valid_q      <= 1'b0;
                push_ready_q <= 1'b1;
            end else begin
                count_q      <= count_d;
                push_ready_q <= (count_d != FULL_CNT);
                if (push_acc) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end

                case (state_q)
                    S_IDLE: begin
                        if (pop) begin
                            data_q   <= mem[rd_ptr_q];
                            valid_q  <= 1'b1;
                            rd_ptr_q <= rd_ptr_q + PTR_ONE;
                            state_q  <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        valid_q <= 1'b0;
                        if (GAP > 1) begin
                            gap_cnt_q <= GAP_LOAD;
                            state_q   <= S_GAP;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt_q == '0) begin
                            state_q <= S_IDLE;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - GAP_ONE;
                        end
                    end
                    default: begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign oPush_ready = push_ready_q;
    assign oCount      = count_q;
    assign oOverflow   = ovf_q;
    assign oFIFO_valid = valid_q;
    assign oFIFO_data  = data_q;

endmodule
